quad_pulse_gen: RTL

- Quadrature A/B signal generator: transmitter side of the minibot encoder interface.
- Emits a commanded signed number of quadrature edges at a programmable rate.
- Drives encoder inputs for bench/self-test (loopback into the encoder counter) and for emulating a wheel when no motor is attached.
- Commands come from the SPI register path; output pins go to GPIO_1 or an internal loopback mux.

---
 rtl/quad_pulse_gen.sv | 139 +++++++++++++
 1 files changed

// File: rtl/quad_pulse_gen.sv
// Quadrature A/B pulse generator: emits a signed number of Gray-coded edges at a programmable period.
// Define QGEN_INDEX_EN to add a mod-CPR position counter and the Z index output.
module quad_pulse_gen #(
  parameter int CNT_W = 32,
  parameter int DIV_W = 20,
  parameter int CPR   = 1024
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic signed [CNT_W-1:0] steps,
  input  logic        [DIV_W-1:0] period,
  input  logic                    abort,
  output logic                    A,
  output logic                    B,
  output logic                    Z,
  output logic                    busy,
  output logic                    done,
  output logic        [CNT_W-1:0] remaining
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);

  // Two's-complement magnitude; the most negative value maps to 2^(CNT_W-1) unsigned.
  function automatic logic [CNT_W-1:0] magnitude(input logic signed [CNT_W-1:0] v);
    logic [CNT_W-1:0] u;
    u = v;
    return v[CNT_W-1] ? (~u + CNT_ONE) : u;
  endfunction

  function automatic logic [DIV_W-1:0] clamp_period(input logic [DIV_W-1:0] p);
    return (p == '0) ? DIV_ONE : p;
  endfunction

  logic [0:0]       state;
  logic             dir;
  logic [DIV_W-1:0] divider;
  logic [DIV_W-1:0] reload;
  logic             step_fire;
  logic [1:0]       idx;
  logic [1:0]       idx_n;
  logic             a_n;
  logic             b_n;

  // Phase index {A, A^B} counts 0..3 along the forward sequence 00,01,11,10.
  always_comb begin
    idx       = {A, A ^ B};
    step_fire = (state == ST_RUN) && !abort && (divider == '0);
    idx_n     = idx;
    if (step_fire) idx_n = dir ? (idx + 2'd1) : (idx - 2'd1);
    a_n = idx_n[1];
    b_n = idx_n[1] ^ idx_n[0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      dir       <= 1'b0;
      divider   <= '0;
      reload    <= '0;
      remaining <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      A         <= 1'b0;
      B         <= 1'b0;
    end else begin
      done <= 1'b0;
      A    <= a_n;
      B    <= b_n;
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (steps != '0) begin
              dir       <= ~steps[CNT_W-1];
              remaining <= magnitude(steps);
              reload    <= clamp_period(period) - DIV_ONE;
              divider   <= clamp_period(period) - DIV_ONE;
              busy      <= 1'b1;
              state     <= ST_RUN;
            end else begin
              done <= 1'b1;
            end
          end
        end
        default: begin
          if (abort) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            remaining <= '0;
          end else if (divider == '0) begin
            remaining <= remaining - CNT_ONE;
            divider   <= reload;
            if (remaining == CNT_ONE) begin
              state <= ST_IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end else begin
            divider <= divider - DIV_ONE;
          end
        end
      endcase
    end
  end

`ifdef QGEN_INDEX_EN
  localparam int POS_W = (CPR > 1) ? $clog2(CPR) : 1;
  localparam logic [POS_W-1:0] POS_MAX = POS_W'(CPR - 1);
  localparam logic [POS_W-1:0] POS_ONE = POS_W'(1);

  logic [POS_W-1:0] pos;
  logic [POS_W-1:0] pos_n;

  always_comb begin
    pos_n = pos;
    if (step_fire) begin
      if (dir) pos_n = (pos == POS_MAX) ? '0 : (pos + POS_ONE);
      else     pos_n = (pos == '0) ? POS_MAX : (pos - POS_ONE);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pos <= '0;
      Z   <= 1'b0;
    end else begin
      pos <= pos_n;
      Z   <= (pos_n == '0) && !a_n && !b_n;
    end
  end
`else
  assign Z = 1'b0;
`endif

endmodule
